// File: rtl/spi_char_sequencer.sv
// spi_char_sequencer: frames CHAR_NBITS characters from a TX FIFO through an external char engine into an RX FIFO,
// with chip-select setup/hold timing around each frame.
module spi_char_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  parameter bit PASS_FULL = 1'b0
) (
  input  logic         S_SYSCLK,
  input  logic         S_RESET,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  // PASS_FULL lets a push land on a full FIFO when the same edge frees a slot
  assign do_push = push && (!full || (PASS_FULL && do_pop));
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge S_SYSCLK)
    if (do_push && !S_RESET) mem[wp[AW-1:0]] <= din;
endmodule

module spi_char_sequencer #(
  parameter int CHAR_NBITS = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CS_DLY = 2
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESET,
  input  logic                  S_ENABLE,
  input  logic                  S_TX_ONLY,
  input  logic                  S_XFER_START,
  input  logic [7:0]            S_XFER_NCHARS,
  output logic                  S_XFER_BUSY,
  output logic                  S_XFER_DONE,
  input  logic                  S_TX_WE,
  input  logic [CHAR_NBITS-1:0] S_TX_DATA,
  output logic                  S_TX_FULL,
  input  logic                  S_RX_RE,
  output logic [CHAR_NBITS-1:0] S_RX_DATA,
  output logic                  S_RX_EMPTY,
  output logic                  S_RX_OVF,
  input  logic                  S_OVF_CLR,
  output logic                  S_SPI_CS_N,
  output logic                  S_CHAR_GO,
  output logic [CHAR_NBITS-1:0] S_WCHAR,
  input  logic                  S_CHAR_DONE,
  input  logic [CHAR_NBITS-1:0] S_RCHAR
);
  typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, GO, WAIT, STORE, CS_HOLD} state_t;
  localparam int DW = CS_DLY > 1 ? $clog2(CS_DLY) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(CS_DLY - 1);
  state_t state, state_nxt;
  logic [DW-1:0] dly;
  logic go_ph, done_q, done_rise;
  logic [8:0] cnt;
  logic tx_empty, tx_pop, rx_full, rx_push, ovf_set;
  logic [CHAR_NBITS-1:0] tx_head;
  assign done_rise = S_CHAR_DONE && !done_q;
  assign tx_pop = state == LOAD && state_nxt == GO;
  assign rx_push = state == STORE && S_ENABLE && !S_TX_ONLY;
  assign ovf_set = rx_push && rx_full && !S_RX_RE;
  assign S_XFER_BUSY = state != IDLE;
  assign S_SPI_CS_N = state == IDLE;
  assign S_CHAR_GO = state == GO;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = S_XFER_START ? CS_SETUP : IDLE;
      CS_SETUP: state_nxt = dly == DLY_LAST ? LOAD : CS_SETUP;
      LOAD:     state_nxt = tx_empty ? LOAD : GO;
      GO:       state_nxt = go_ph ? WAIT : GO;
      WAIT:     state_nxt = done_rise ? STORE : WAIT;
      STORE:    state_nxt = cnt == 9'd1 ? CS_HOLD : LOAD;
      CS_HOLD:  state_nxt = dly == DLY_LAST ? IDLE : CS_HOLD;
      default:  state_nxt = IDLE;
    endcase
    if (!S_ENABLE) state_nxt = IDLE;
  end
  always_ff @(posedge S_SYSCLK)
    state <= S_RESET ? IDLE : state_nxt;
  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      dly <= '0;
      go_ph <= 1'b0;
      done_q <= 1'b0;
      cnt <= '0;
      S_WCHAR <= '1;
      S_XFER_DONE <= 1'b0;
      S_RX_OVF <= 1'b0;
    end else begin
      dly <= state_nxt == state ? dly + 1'b1 : '0;
      go_ph <= state == GO && !go_ph;
      done_q <= S_CHAR_DONE;
      // an 8-bit count of zero becomes 256 via the ninth bit
      if (state == IDLE && state_nxt == CS_SETUP) cnt <= {S_XFER_NCHARS == 8'd0, S_XFER_NCHARS};
      else if (state == STORE && S_ENABLE) cnt <= cnt - 1'b1;
      if (tx_pop) S_WCHAR <= tx_head;
      S_XFER_DONE <= state == CS_HOLD && state_nxt == IDLE && S_ENABLE;
      S_RX_OVF <= ovf_set | (S_RX_OVF & ~S_OVF_CLR);
    end
  end
  spi_char_fifo #(.W(CHAR_NBITS), .DEPTH(FIFO_DEPTH), .PASS_FULL(1'b0)) u_tx (
    .S_SYSCLK(S_SYSCLK), .S_RESET(S_RESET), .push(S_TX_WE), .din(S_TX_DATA), .pop(tx_pop),
    .dout(tx_head), .full(S_TX_FULL), .empty(tx_empty)
  );
  spi_char_fifo #(.W(CHAR_NBITS), .DEPTH(FIFO_DEPTH), .PASS_FULL(1'b1)) u_rx (
    .S_SYSCLK(S_SYSCLK), .S_RESET(S_RESET), .push(rx_push), .din(S_RCHAR), .pop(S_RX_RE),
    .dout(S_RX_DATA), .full(rx_full), .empty(S_RX_EMPTY)
  );
endmodule

// File: tb/tb_spi_char_sequencer.sv
// tb_spi_char_sequencer: randomized frames against a queue-based FIFO/char-engine reference model.
module tb_spi_char_sequencer;
  localparam int W = 32, D = 8, CD = 2;
  logic S_SYSCLK = 1'b0, S_RESET = 1'b1, S_ENABLE = 1'b0, S_TX_ONLY = 1'b0, S_XFER_START = 1'b0;
  logic [7:0] S_XFER_NCHARS = '0;
  logic S_TX_WE = 1'b0, S_RX_RE = 1'b0, S_OVF_CLR = 1'b0, S_CHAR_DONE = 1'b0;
  logic [W-1:0] S_TX_DATA = '0, S_RCHAR = '0;
  logic S_XFER_BUSY, S_XFER_DONE, S_TX_FULL, S_RX_EMPTY, S_RX_OVF, S_SPI_CS_N, S_CHAR_GO;
  logic [W-1:0] S_RX_DATA, S_WCHAR;

  spi_char_sequencer #(.CHAR_NBITS(W), .FIFO_DEPTH(D), .CS_DLY(CD)) dut (
    .S_SYSCLK(S_SYSCLK), .S_RESET(S_RESET), .S_ENABLE(S_ENABLE), .S_TX_ONLY(S_TX_ONLY),
    .S_XFER_START(S_XFER_START), .S_XFER_NCHARS(S_XFER_NCHARS), .S_XFER_BUSY(S_XFER_BUSY),
    .S_XFER_DONE(S_XFER_DONE), .S_TX_WE(S_TX_WE), .S_TX_DATA(S_TX_DATA), .S_TX_FULL(S_TX_FULL),
    .S_RX_RE(S_RX_RE), .S_RX_DATA(S_RX_DATA), .S_RX_EMPTY(S_RX_EMPTY), .S_RX_OVF(S_RX_OVF),
    .S_OVF_CLR(S_OVF_CLR), .S_SPI_CS_N(S_SPI_CS_N), .S_CHAR_GO(S_CHAR_GO), .S_WCHAR(S_WCHAR),
    .S_CHAR_DONE(S_CHAR_DONE), .S_RCHAR(S_RCHAR)
  );

  always #5 S_SYSCLK = ~S_SYSCLK;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge S_SYSCLK) cyc <= cyc + 1;

  // reference model: accepted-but-unsent TX words, words sent in order, expected RX contents
  logic [W-1:0] exp_tx[$], exp_sent[$], exp_rx[$], go_words[$], rx_got[$];
  bit ovf_exp = 0;
  int go_cnt, go_cyc_total, done_cnt, cs_rises, first_go_cyc, cs_fall_cyc, cs_rise_cyc, last_cd_cyc;
  bit rx_nonempty_seen;
  logic go_q = 1'b0, cs_q = 1'b1;

  always @(negedge S_SYSCLK) begin
    if (S_CHAR_GO && !go_q) begin
      go_words.push_back(S_WCHAR);
      if (exp_tx.size() > 0) exp_sent.push_back(exp_tx.pop_front());
      if (go_cnt == 0) first_go_cyc = cyc;
      go_cnt++;
    end
    if (S_CHAR_GO) go_cyc_total++;
    if (S_XFER_DONE) done_cnt++;
    if (!S_SPI_CS_N && cs_q) cs_fall_cyc = cyc;
    if (S_SPI_CS_N && !cs_q) begin
      cs_rise_cyc = cyc;
      cs_rises++;
    end
    if (!S_RX_EMPTY) rx_nonempty_seen = 1;
    go_q = S_CHAR_GO;
    cs_q = S_SPI_CS_N;
  end

  // char engine: answers each GO with ~WCHAR after a random latency
  bit eng_en = 1;
  logic [W-1:0] eng_w;
  initial begin
    forever begin
      @(negedge S_SYSCLK);
      if (S_CHAR_GO && eng_en) begin
        eng_w = S_WCHAR;
        while (S_CHAR_GO) @(negedge S_SYSCLK);
        repeat ($urandom_range(0, 3)) @(negedge S_SYSCLK);
        S_RCHAR = ~eng_w;
        S_CHAR_DONE = 1'b1;
        last_cd_cyc = cyc;
        if (!S_TX_ONLY) begin
          if (exp_rx.size() < D) exp_rx.push_back(~eng_w);
          else ovf_exp = 1;
        end
        @(negedge S_SYSCLK);
        S_CHAR_DONE = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge S_SYSCLK);
  endtask

  task automatic clear_mon();
    go_cnt = 0; go_cyc_total = 0; done_cnt = 0; cs_rises = 0; first_go_cyc = -1;
    rx_nonempty_seen = 0;
    go_words.delete();
    exp_sent.delete();
  endtask

  task automatic tx_write(input logic [W-1:0] w);
    @(negedge S_SYSCLK);
    S_TX_WE = 1'b1;
    S_TX_DATA = w;
    if (exp_tx.size() < D) exp_tx.push_back(w);
    @(negedge S_SYSCLK);
    S_TX_WE = 1'b0;
  endtask

  task automatic start(input logic [7:0] n);
    @(negedge S_SYSCLK);
    S_XFER_START = 1'b1;
    S_XFER_NCHARS = n;
    @(negedge S_SYSCLK);
    S_XFER_START = 1'b0;
  endtask

  task automatic wait_done(output bit ok, input int budget);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge S_SYSCLK);
      if (done_cnt > d0) ok = 1;
    end
    tick(3);
  endtask

  task automatic read_all();
    rx_got.delete();
    @(negedge S_SYSCLK);
    for (int i = 0; i < 2 * D && !S_RX_EMPTY; i++) begin
      rx_got.push_back(S_RX_DATA);
      S_RX_RE = 1'b1;
      @(negedge S_SYSCLK);
    end
    S_RX_RE = 1'b0;
    @(negedge S_SYSCLK);
  endtask

  task automatic test_reset();
    S_RESET = 1'b1;
    tick(3);
    S_RESET = 1'b0;
    S_ENABLE = 1'b1;
    tick(1);
    tests++; if (S_SPI_CS_N !== 1'b1) begin fails++; $display("FAIL reset_cs_n got %b want 1", S_SPI_CS_N); end
    tests++; if (S_CHAR_GO !== 1'b0) begin fails++; $display("FAIL reset_go got %b want 0", S_CHAR_GO); end
    tests++; if (S_WCHAR !== {W{1'b1}}) begin fails++; $display("FAIL reset_wchar got %h want all ones", S_WCHAR); end
    tests++; if (S_XFER_BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", S_XFER_BUSY); end
    tests++; if (S_XFER_DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", S_XFER_DONE); end
    tests++; if (S_TX_FULL !== 1'b0) begin fails++; $display("FAIL reset_tx_full got %b want 0", S_TX_FULL); end
    tests++; if (S_RX_EMPTY !== 1'b1) begin fails++; $display("FAIL reset_rx_empty got %b want 1", S_RX_EMPTY); end
    tests++; if (S_RX_OVF !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", S_RX_OVF); end
  endtask

  task automatic test_basic_frame();
    bit ok;
    S_TX_ONLY = 1'b0;
    clear_mon();
    tx_write(32'hA5A5A5A5);
    tx_write(32'h3C3C3C3C);
    start(8'd2);
    wait_done(ok, 2000);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_timeout got none want DONE"); end
    tests++; if (go_cnt !== 2 || go_cyc_total !== 4) begin fails++; $display("FAIL basic_go got %0d pulses/%0d cycles want 2/4", go_cnt, go_cyc_total); end
    tests++; if (go_words.size() != 2 || go_words[0] !== 32'hA5A5A5A5 || go_words[1] !== 32'h3C3C3C3C) begin fails++; $display("FAIL basic_wchar got %0d words want A5A5A5A5,3C3C3C3C", go_words.size()); end
    tests++; if (first_go_cyc - cs_fall_cyc !== CD + 1) begin fails++; $display("FAIL basic_cs_setup got %0d want %0d", first_go_cyc - cs_fall_cyc, CD + 1); end
    tests++; if (cs_rise_cyc - last_cd_cyc !== CD + 2) begin fails++; $display("FAIL basic_cs_hold got %0d want %0d", cs_rise_cyc - last_cd_cyc, CD + 2); end
    tests++; if (done_cnt !== 1 || cs_rises !== 1) begin fails++; $display("FAIL basic_done_count got done=%0d cs_rises=%0d want 1/1", done_cnt, cs_rises); end
    read_all();
    tests++; if (rx_got.size() != 2 || rx_got[0] !== 32'h5A5A5A5A || rx_got[1] !== 32'hC3C3C3C3) begin fails++; $display("FAIL basic_rx got %0d words want 5A5A5A5A,C3C3C3C3", rx_got.size()); end
    exp_rx.delete();
  endtask

  task automatic test_tx_stall();
    bit ok;
    int wc;
    clear_mon();
    start(8'd1);
    tick(20);
    tests++; if (go_cnt !== 0 || S_SPI_CS_N !== 1'b0 || S_XFER_BUSY !== 1'b1) begin fails++; $display("FAIL stall_hold got go=%0d cs_n=%b busy=%b want 0/0/1", go_cnt, S_SPI_CS_N, S_XFER_BUSY); end
    @(negedge S_SYSCLK);
    wc = cyc;
    S_TX_WE = 1'b1;
    S_TX_DATA = 32'h11;
    exp_tx.push_back(32'h11);
    @(negedge S_SYSCLK);
    S_TX_WE = 1'b0;
    wait_done(ok, 2000);
    tests++; if (!ok || done_cnt !== 1) begin fails++; $display("FAIL stall_done got ok=%0d done=%0d want 1/1", ok, done_cnt); end
    tests++; if (first_go_cyc !== wc + 2) begin fails++; $display("FAIL stall_go_latency got %0d want %0d", first_go_cyc - wc, 2); end
    tests++; if (cs_rises !== 1 || go_words.size() != 1 || go_words[0] !== 32'h11) begin fails++; $display("FAIL stall_frame got cs_rises=%0d words=%0d want 1/1 with 00000011", cs_rises, go_words.size()); end
    read_all();
    tests++; if (rx_got.size() != 1 || rx_got[0] !== 32'hFFFFFFEE) begin fails++; $display("FAIL stall_rx got %0d words want FFFFFFEE", rx_got.size()); end
    exp_rx.delete();
  endtask

  task automatic test_random_frames();
    bit ok;
    int n, bad;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, D);
      S_TX_ONLY = 1'($urandom_range(0, 1));
      clear_mon();
      for (int i = 0; i < n; i++) tx_write($urandom);
      start(8'(n));
      wait_done(ok, 3000);
      bad = 0;
      for (int i = 0; i < n && i < go_words.size() && i < exp_sent.size(); i++) if (go_words[i] !== exp_sent[i]) bad++;
      tests++; if (!ok || go_cnt !== n || exp_sent.size() != n || bad != 0) begin fails++; $display("FAIL rand_tx frame %0d got go=%0d bad=%0d want go=%0d bad=0", f, go_cnt, bad, n); end
      read_all();
      bad = 0;
      for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++) if (rx_got[i] !== exp_rx[i]) bad++;
      tests++; if (rx_got.size() != exp_rx.size() || bad != 0 || rx_got.size() != (S_TX_ONLY ? 0 : n)) begin fails++; $display("FAIL rand_rx frame %0d got %0d words bad=%0d want %0d words", f, rx_got.size(), bad, S_TX_ONLY ? 0 : n); end
      exp_rx.delete();
    end
    S_TX_ONLY = 1'b0;
  endtask

  task automatic test_count_256();
    bit ok;
    int bad;
    S_TX_ONLY = 1'b1;
    clear_mon();
    start(8'd0);
    for (int i = 0; i < 256; i++) begin
      for (int g = 0; g < 200 && exp_tx.size() >= D; g++) @(negedge S_SYSCLK);
      tx_write($urandom);
    end
    wait_done(ok, 6000);
    bad = 0;
    for (int i = 0; i < go_words.size() && i < exp_sent.size(); i++) if (go_words[i] !== exp_sent[i]) bad++;
    tests++; if (!ok || go_cnt !== 256 || bad != 0) begin fails++; $display("FAIL count_256 got go=%0d bad=%0d ok=%0d want 256/0/1", go_cnt, bad, ok); end
    tests++; if (S_RX_EMPTY !== 1'b1 || done_cnt !== 1) begin fails++; $display("FAIL count_256_end got rx_empty=%b done=%0d want 1/1", S_RX_EMPTY, done_cnt); end
    S_TX_ONLY = 1'b0;
  endtask

  task automatic test_rx_overflow();
    bit ok;
    int bad;
    logic [W-1:0] wv[9];
    S_TX_ONLY = 1'b0;
    clear_mon();
    for (int i = 0; i < 9; i++) wv[i] = $urandom;
    for (int i = 0; i < 8; i++) tx_write(wv[i]);
    start(8'd9);
    for (int g = 0; g < 500 && go_cnt == 0; g++) @(negedge S_SYSCLK);
    tx_write(wv[8]);
    wait_done(ok, 3000);
    tests++; if (!ok || go_cnt !== 9) begin fails++; $display("FAIL ovf_frame got go=%0d ok=%0d want 9/1", go_cnt, ok); end
    tests++; if (S_RX_OVF !== ovf_exp || !ovf_exp) begin fails++; $display("FAIL ovf_flag got %b want %b", S_RX_OVF, ovf_exp); end
    read_all();
    bad = 0;
    for (int i = 0; i < rx_got.size() && i < 8; i++) if (rx_got[i] !== ~wv[i]) bad++;
    tests++; if (rx_got.size() != 8 || bad != 0) begin fails++; $display("FAIL ovf_retained got %0d words bad=%0d want 8/0", rx_got.size(), bad); end
    @(negedge S_SYSCLK);
    S_OVF_CLR = 1'b1;
    @(negedge S_SYSCLK);
    S_OVF_CLR = 1'b0;
    ovf_exp = 0;
    tests++; if (S_RX_OVF !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", S_RX_OVF); end
    exp_rx.delete();
  endtask

  task automatic test_tx_only();
    bit ok;
    S_TX_ONLY = 1'b1;
    clear_mon();
    for (int i = 0; i < 3; i++) tx_write($urandom);
    start(8'd3);
    wait_done(ok, 2000);
    tests++; if (!ok || done_cnt !== 1 || go_cnt !== 3) begin fails++; $display("FAIL txonly_done got done=%0d go=%0d want 1/3", done_cnt, go_cnt); end
    tests++; if (rx_nonempty_seen || S_RX_EMPTY !== 1'b1) begin fails++; $display("FAIL txonly_rx_empty got seen_nonempty=%0d want 0", rx_nonempty_seen); end
    S_TX_ONLY = 1'b0;
  endtask

  task automatic test_tx_full_wrap();
    bit ok;
    int bad;
    logic [W-1:0] wv[9];
    S_TX_ONLY = 1'b1;
    clear_mon();
    for (int i = 0; i < 9; i++) wv[i] = $urandom;
    for (int i = 0; i < 7; i++) tx_write(wv[i]);
    tests++; if (S_TX_FULL !== 1'b0) begin fails++; $display("FAIL txfull_7 got %b want 0", S_TX_FULL); end
    tx_write(wv[7]);
    tests++; if (S_TX_FULL !== 1'b1) begin fails++; $display("FAIL txfull_8 got %b want 1", S_TX_FULL); end
    tx_write(wv[8]);
    start(8'd8);
    wait_done(ok, 3000);
    bad = 0;
    for (int i = 0; i < go_words.size() && i < 8; i++) if (go_words[i] !== wv[i]) bad++;
    tests++; if (!ok || go_words.size() != 8 || bad != 0) begin fails++; $display("FAIL txfull_order got %0d words bad=%0d want 8/0", go_words.size(), bad); end
    tests++; if (S_TX_FULL !== 1'b0 || exp_tx.size() != 0) begin fails++; $display("FAIL txfull_drop9 got full=%b leftover=%0d want 0/0", S_TX_FULL, exp_tx.size()); end
    S_TX_ONLY = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom;
    eng_en = 0;
    clear_mon();
    tx_write(a);
    tx_write(b);
    start(8'd2);
    for (int g = 0; g < 200 && go_cnt == 0; g++) @(negedge S_SYSCLK);
    for (int g = 0; g < 20 && S_CHAR_GO; g++) @(negedge S_SYSCLK);
    tick(2);
    S_ENABLE = 1'b0;
    @(negedge S_SYSCLK);
    tests++; if (S_XFER_BUSY !== 1'b0 || S_SPI_CS_N !== 1'b1 || S_CHAR_GO !== 1'b0) begin fails++; $display("FAIL abort_idle got busy=%b cs_n=%b go=%b want 0/1/0", S_XFER_BUSY, S_SPI_CS_N, S_CHAR_GO); end
    S_ENABLE = 1'b1;
    tick(4);
    tests++; if (done_cnt !== 0 || go_cnt !== 1) begin fails++; $display("FAIL abort_no_done got done=%0d go=%0d want 0/1", done_cnt, go_cnt); end
    eng_en = 1;
    clear_mon();
    start(8'd1);
    wait_done(ok, 2000);
    tests++; if (!ok || go_words.size() != 1 || go_words[0] !== b) begin fails++; $display("FAIL abort_retained got %0d words want %h", go_words.size(), b); end
    read_all();
    tests++; if (rx_got.size() != 1 || rx_got[0] !== ~b) begin fails++; $display("FAIL abort_rx got %0d words want %h", rx_got.size(), ~b); end
    exp_rx.delete();
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    clear_mon();
    tx_write($urandom);
    start(8'd1);
    wait_done(ok, 2000);
    eng_en = 0;
    clear_mon();
    tx_write($urandom);
    start(8'd1);
    for (int g = 0; g < 200 && go_cnt == 0; g++) @(negedge S_SYSCLK);
    for (int g = 0; g < 20 && S_CHAR_GO; g++) @(negedge S_SYSCLK);
    for (int i = 0; i < D; i++) tx_write($urandom);
    tests++; if (!ok || S_TX_FULL !== 1'b1 || S_RX_EMPTY !== 1'b0 || S_XFER_BUSY !== 1'b1) begin fails++; $display("FAIL rstwait_pre got full=%b rx_empty=%b busy=%b want 1/0/1", S_TX_FULL, S_RX_EMPTY, S_XFER_BUSY); end
    S_RESET = 1'b1;
    @(negedge S_SYSCLK);
    tests++; if (S_SPI_CS_N !== 1'b1 || S_XFER_BUSY !== 1'b0 || S_TX_FULL !== 1'b0 || S_RX_EMPTY !== 1'b1) begin fails++; $display("FAIL rstwait_post got cs_n=%b busy=%b full=%b rx_empty=%b want 1/0/0/1", S_SPI_CS_N, S_XFER_BUSY, S_TX_FULL, S_RX_EMPTY); end
    S_RESET = 1'b0;
    tick(4);
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL rstwait_no_done got %0d want 0", done_cnt); end
    exp_tx.delete();
    exp_rx.delete();
    ovf_exp = 0;
    eng_en = 1;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_tx_stall();
    test_random_frames();
    test_count_256();
    test_rx_overflow();
    test_tx_only();
    test_tx_full_wrap();
    test_abort();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_char_sequencer.md
SPI_CHAR_SEQUENCER -- requirements
Module: spi_char_sequencer

Interface
REQ-001 SHALL have parameter CHAR_NBITS, default 32, character width matching the downstream char engine.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO (power of two).
REQ-003 SHALL have parameter CS_DLY, default 2, sysclk cycles of CS setup and hold.
REQ-004 SHALL have S_SYSCLK  in  1  platform clock; one clock only, all logic on its rising edge.
REQ-005 SHALL have S_RESET  in  1  synchronous active-high reset.
REQ-006 SHALL have S_ENABLE  in  1  block enable; low forces IDLE on the next edge.
REQ-007 SHALL have S_TX_ONLY  in  1  discard received characters.
REQ-008 SHALL have S_XFER_START  in  1  one-cycle frame start request.
REQ-009 SHALL have S_XFER_NCHARS  in  8  characters per frame; 0 means 256.
REQ-010 SHALL have S_XFER_BUSY  out  1  high while not IDLE.
REQ-011 SHALL have S_XFER_DONE  out  1  one-cycle frame-complete pulse.
REQ-012 SHALL have S_TX_WE / S_TX_DATA / S_TX_FULL  in / in / out  1 / CHAR_NBITS / 1  TX FIFO write port.
REQ-013 SHALL have S_RX_RE / S_RX_DATA / S_RX_EMPTY  in / out / out  1 / CHAR_NBITS / 1  RX FIFO read port; S_RX_DATA shows the head entry (first-word fall-through).
REQ-014 SHALL have S_RX_OVF / S_OVF_CLR  out / in  1 / 1  sticky RX overflow flag and its clear.
REQ-015 SHALL have S_SPI_CS_N  out  1  active-low chip select.
REQ-016 SHALL have S_CHAR_GO / S_WCHAR  out / out  1 / CHAR_NBITS  char-engine start and transmit word.
REQ-017 SHALL have S_CHAR_DONE / S_RCHAR  in / in  1 / CHAR_NBITS  char-engine completion and received word.

Function
REQ-018 SHALL implement states IDLE, CS_SETUP, LOAD, GO, WAIT, STORE, CS_HOLD.
REQ-019 In IDLE, S_XFER_START with S_ENABLE high SHALL latch the frame count (9-bit, 0 maps to 256), enter CS_SETUP, and drive S_SPI_CS_N low on the same edge; START while busy SHALL be ignored.
REQ-020 CS_SETUP SHALL last exactly CS_DLY cycles, then enter LOAD.
REQ-021 LOAD SHALL stall, CS held low, while the TX FIFO is empty; when it is non-empty, it SHALL pop the head into S_WCHAR and enter GO in one cycle.
REQ-022 GO SHALL drive S_CHAR_GO high for exactly 2 cycles with S_WCHAR stable, then enter WAIT; S_WCHAR SHALL remain stable until STORE.
REQ-023 WAIT SHALL leave on the first sysclk rising edge of S_CHAR_DONE (registered edge detect) and enter STORE; a level already high on entry SHALL NOT count.
REQ-024 STORE SHALL capture S_RCHAR into the RX FIFO unless S_TX_ONLY; when the RX FIFO is full the word SHALL be dropped and S_RX_OVF set.
REQ-025 STORE SHALL decrement the count and enter LOAD if the result is nonzero, else CS_HOLD.
REQ-026 CS_HOLD SHALL last CS_DLY cycles, then raise S_SPI_CS_N, pulse S_XFER_DONE for one cycle, and return to IDLE.
REQ-027 Each FIFO SHALL use binary pointers one bit wider than log2(FIFO_DEPTH), wrap modulo 2*FIFO_DEPTH, and set full when MSBs differ and LSBs match.
REQ-028 A TX write when full and an RX read when empty SHALL be ignored without corrupting pointers.
REQ-029 A simultaneous TX write and internal pop on a full FIFO SHALL drop the write; simultaneous read and push on a full RX FIFO SHALL accept both.
REQ-030 S_OVF_CLR SHALL clear S_RX_OVF; a simultaneous set SHALL win.
REQ-031 S_ENABLE going low mid-frame SHALL abort: IDLE, CS_N high, S_CHAR_GO low, no S_XFER_DONE, with FIFO contents retained.

Reset
REQ-032 S_RESET SHALL override all other inputs and put the block in IDLE with both FIFOs empty and pointers 0.
REQ-033 Reset values: S_SPI_CS_N=1, S_CHAR_GO=0, S_WCHAR=all ones, S_XFER_BUSY=0, S_XFER_DONE=0, S_TX_FULL=0, S_RX_EMPTY=1, S_RX_OVF=0.
REQ-034 Reset asserted mid-frame SHALL take effect on the next edge, with CS_N high and no S_XFER_DONE.

Verification
REQ-035 Write 0xA5A5A5A5, 0x3C3C3C3C; START with NCHARS=2; char-engine model returns ~WCHAR -> two GO pulses, RX reads 0x5A5A5A5A then 0xC3C3C3C3, CS low for CS_DLY+frame+CS_DLY, one DONE pulse.
REQ-036 START with NCHARS=1 and TX empty; write 0x11 after 20 cycles -> CS low throughout, GO 1 cycle after the write, DONE after completion.
REQ-037 Send 9 characters with S_TX_ONLY=0, no RX reads, FIFO_DEPTH=8 -> 8 entries retained, S_RX_OVF=1; OVF_CLR -> 0.
REQ-038 S_TX_ONLY=1, NCHARS=3 -> S_RX_EMPTY stays 1, DONE pulses once.
REQ-039 Write 9 words into the TX FIFO -> S_TX_FULL after 8, 9th dropped, pop order intact across pointer wrap.
REQ-040 Assert S_RESET during WAIT -> next cycle CS_N=1, BUSY=0, TX_FULL=0, RX_EMPTY=1, no DONE.
